// File: rtl/duty_permille_bcd.sv
// Duty cycle in permille, floor(high*1000/(high+low)), via a serial restoring
// divider followed by a serial double-dabble into four BCD display digits.
module duty_permille_bcd #(
   parameter int CNT_W = 32
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] high_cnt,
   input  logic [CNT_W-1:0] low_cnt,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       digit3,
   output logic [3:0]       digit2,
   output logic [3:0]       digit1,
   output logic [3:0]       digit0,
   output logic [2:0]       dbg_state_o
);

   localparam int NUM_W = CNT_W + 10;
   localparam int DEN_W = CNT_W + 1;
   localparam int REM_W = CNT_W + 2;
   localparam int CW    = $clog2(NUM_W + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_DIV  = 3'd2,
      S_BCD  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   high_q, high_d;
   logic [CNT_W-1:0]   low_q, low_d;
   logic [DEN_W-1:0]   den_q, den_d;
   logic [NUM_W-1:0]   num_q, num_d;
   logic [DEN_W-1:0]   rem_q, rem_d;
   logic [9:0]         bin_q, bin_d;
   logic [15:0]        bcd_q, bcd_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [15:0]        dig_q, dig_d;

   logic [NUM_W-1:0]   h_ext;
   logic [DEN_W-1:0]   den_w;
   logic [REM_W-1:0]   rem_sh;
   logic [DEN_W-1:0]   rem_diff;
   logic [14:0]        bcd_adj;

   assign h_ext    = NUM_W'(high_q);
   assign den_w    = DEN_W'(high_q) + DEN_W'(low_q);
   assign rem_sh   = {rem_q, num_q[NUM_W-1]};
   // The true difference is below den, so DEN_W bits of modular subtraction suffice.
   assign rem_diff = rem_sh[DEN_W-1:0] - den_q;

   // Thousands nibble never exceeds 1, so it never needs the +3 correction.
   always_comb begin
      bcd_adj[14:12] = bcd_q[14:12];
      for (int i = 0; i < 3; i++) begin
         bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                        : bcd_q[i*4 +: 4];
      end
   end

   // Handshake: start is a one-cycle request honoured only while busy=0; busy
   // rises on the accepting edge and falls on the edge that pulses done.
   always_comb begin
      state_d = state_q;
      high_d  = high_q;
      low_d   = low_q;
      den_d   = den_q;
      num_d   = num_q;
      rem_d   = rem_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      dig_d   = dig_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               high_d  = high_cnt;
               low_d   = low_cnt;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            den_d = den_w;
            num_d = (h_ext << 10) - (h_ext << 4) - (h_ext << 3);
            if (den_w == '0) begin
               err_d   = 1'b1;
               bcd_d   = '0;
               state_d = S_DONE;
            end else begin
               rem_d   = '0;
               bin_d   = '0;
               cnt_d   = CW'(NUM_W - 1);
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            num_d = num_q << 1;
            if (rem_sh >= REM_W'(den_q)) begin
               rem_d = rem_diff;
               bin_d = {bin_q[8:0], 1'b1};
            end else begin
               rem_d = rem_sh[DEN_W-1:0];
               bin_d = {bin_q[8:0], 1'b0};
            end
            if (cnt_q == '0) begin
               bcd_d   = '0;
               cnt_d   = CW'(9);
               state_d = S_BCD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_BCD: begin
            bcd_d = {bcd_adj, bin_q[9]};
            bin_d = {bin_q[8:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            dig_d   = bcd_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         high_q  <= '0;
         low_q   <= '0;
         den_q   <= '0;
         num_q   <= '0;
         rem_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         high_q  <= high_d;
         low_q   <= low_d;
         den_q   <= den_d;
         num_q   <= num_d;
         rem_q   <= rem_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dig_q   <= dig_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign digit3      = dig_q[15:12];
   assign digit2      = dig_q[11:8];
   assign digit1      = dig_q[7:4];
   assign digit0      = dig_q[3:0];
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_duty_permille_bcd.sv
// Bench for duty_permille_bcd: directed and random count pairs checked against
// an arithmetic permille/decimal-digit model, plus latency, busy, err and abort cases.
module tb_duty_permille_bcd;

   localparam int CNT_W   = 32;
   localparam int LAT_OK  = CNT_W + 22;
   localparam int LAT_ERR = 2;

   logic             sys_clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] low_cnt;
   logic             busy;
   logic             done;
   logic             err;
   logic [3:0]       digit3, digit2, digit1, digit0;
   logic [2:0]       dbg_state;

   int tests = 0;
   int fails = 0;

   always #5 sys_clk = ~sys_clk;

   duty_permille_bcd #(.CNT_W(CNT_W)) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .start       (start),
      .high_cnt    (high_cnt),
      .low_cnt     (low_cnt),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .digit3      (digit3),
      .digit2      (digit2),
      .digit1      (digit1),
      .digit0      (digit0),
      .dbg_state_o (dbg_state)
   );

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer permille, then decimal digits by division.
   function automatic logic [15:0] ref_bcd(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] l);
      logic [63:0] den;
      logic [63:0] duty;
      den = 64'(h) + 64'(l);
      if (den == 0) return 16'h0000;
      duty = (64'(h) * 64'd1000) / den;
      return {4'(duty / 1000), 4'((duty / 100) % 10), 4'((duty / 10) % 10), 4'(duty % 10)};
   endfunction

   // Issues one start and watches n_edges further edges; optionally pokes a
   // second start (900/100) or asserts rst before the numbered edge.
   task automatic run_op(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] l,
                         input int poke_edge, input int rst_edge, input int n_edges,
                         output int first_done, output int ndone, output int busy_bad);
      first_done = -1;
      ndone      = 0;
      busy_bad   = 0;
      @(negedge sys_clk);
      high_cnt = h;
      low_cnt  = l;
      start    = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      for (int n = 1; n <= n_edges; n++) begin
         @(negedge sys_clk);
         if (n == poke_edge) begin
            high_cnt = 900;
            low_cnt  = 100;
            start    = 1'b1;
         end
         if (n == rst_edge) rst = 1'b1;
         @(posedge sys_clk);
         #1;
         start = 1'b0;
         rst   = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            if (first_done < 0) begin
               first_done = n;
               if (busy !== 1'b0) busy_bad++;
            end
         end else if (first_done < 0 && rst_edge == 0 && busy !== 1'b1) begin
            busy_bad++;
         end
         if (n == rst_edge) begin
            check("abort_busy", 64'(busy), 64'(0));
            check("abort_done", 64'(done), 64'(0));
            check("abort_digits", 64'({digit3, digit2, digit1, digit0}), 64'(0));
            check("abort_state", 64'(dbg_state), 64'(0));
         end
      end
   endtask

   task automatic run_check(input string tag, input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] l);
      int fd, nd, bb;
      logic zero_den;
      zero_den = ((64'(h) + 64'(l)) == 0);
      run_op(h, l, 0, 0, LAT_OK + 6, fd, nd, bb);
      check({tag, "_latency"}, 64'(fd), zero_den ? 64'(LAT_ERR) : 64'(LAT_OK));
      check({tag, "_done_count"}, 64'(nd), 64'(1));
      check({tag, "_busy"}, 64'(bb), 64'(0));
      check({tag, "_digits"}, 64'({digit3, digit2, digit1, digit0}), 64'(ref_bcd(h, l)));
      check({tag, "_err"}, 64'(err), 64'(zero_den));
   endtask

   initial begin
      int fd, nd, bb;
      logic [CNT_W-1:0] h, l;

      rst      = 1'b1;
      start    = 1'b0;
      high_cnt = '0;
      low_cnt  = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_err", 64'(err), 64'(0));
      check("reset_digits", 64'({digit3, digit2, digit1, digit0}), 64'(0));
      check("reset_state", 64'(dbg_state), 64'(0));
      @(negedge sys_clk);
      rst = 1'b0;

      run_check("q250", 250, 750);
      run_check("full1000", 1, 0);
      run_check("third", 1, 2);
      run_check("two_thirds", 2, 1);
      run_check("zero_den", 0, 0);
      run_check("err_clear", 5, 5);
      run_check("max_both", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_check("max_high", 32'hFFFF_FFFF, 0);
      run_check("zero_high", 0, 37);

      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 3))
            0: begin h = $urandom; l = $urandom; end
            1: begin h = $urandom_range(0, 20); l = $urandom_range(0, 20); end
            2: begin h = $urandom; l = $urandom_range(0, 3); end
            default: begin h = $urandom_range(0, 5000); l = $urandom; end
         endcase
         run_check($sformatf("rand%0d", i), h, l);
      end

      run_op(250, 750, 10, 0, LAT_OK + 10, fd, nd, bb);
      check("busy_start_latency", 64'(fd), 64'(LAT_OK));
      check("busy_start_done_count", 64'(nd), 64'(1));
      check("busy_start_busy", 64'(bb), 64'(0));
      check("busy_start_digits", 64'({digit3, digit2, digit1, digit0}), 64'(16'h0250));

      run_op(250, 750, 0, 20, LAT_OK + 10, fd, nd, bb);
      check("abort_done_count", 64'(nd), 64'(0));
      check("abort_digits_hold", 64'({digit3, digit2, digit1, digit0}), 64'(0));
      check("abort_idle_busy", 64'(busy), 64'(0));

      run_check("after_abort", 999, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
